// File: rtl/rx_measure_if.sv
// rx_measure_if: XGMII receive bus plus the shared transmit timestamp.
// master drives the bus, slave is the measurement block.
interface rx_measure_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] global_counter;

  modport master (
    output xgmii_rxd,
    output xgmii_rxc,
    output global_counter
  );

  modport slave (
    input xgmii_rxd,
    input xgmii_rxc,
    input global_counter
  );
endinterface

// File: rtl/rx_measure.sv
// rx_measure: XGMII probe-frame receiver reporting frames, bytes, latency.
// Define RX_LATENCY_MAX_EN to report the per-window maximum latency.
module rx_measure #(
  parameter logic [39:0] MAGIC_CODE = 40'h55_AA_2D_96_C3,
  parameter int unsigned SEC_COUNT  = 156250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  rx_measure_if.slave xgmii,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t state, nstate;

  logic [7:0][7:0] lane;
  logic [7:0]      rxc;
  logic [23:0]     gc;

  assign lane = xgmii.xgmii_rxd;
  assign rxc  = xgmii.xgmii_rxc;
  assign gc   = xgmii.global_counter[23:0];

  logic [31:0] win;
  logic        tick;

  assign tick = (win == 32'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win <= 32'(SEC_COUNT - 1);
    end else if (tick) begin
      win <= 32'(SEC_COUNT - 1);
    end else begin
      win <= win - 32'd1;
    end
  end

  logic       start;
  logic [7:0] is07;
  logic       term_ok;
  logic [2:0] term_k;

  always_comb begin
    start = (rxc == 8'h01) && (lane[0] == 8'hFB);
    is07  = '0;
    for (int k = 0; k < 8; k++) begin
      is07[k] = (lane[k] == 8'h07);
    end
  end

  // clean terminate: data below lane k, FD in lane k, only idles above
  always_comb begin
    term_ok = 1'b0;
    term_k  = '0;
    for (int k = 0; k < 8; k++) begin
      if (!term_ok && rxc == 8'(8'hFF << k) && lane[k] == 8'hFD &&
          (~is07 & 8'(8'hFE << k)) == 8'h00) begin
        term_ok = 1'b1;
        term_k  = 3'(k);
      end
    end
  end

  logic [11:0] widx;
  logic        match;
  logic [31:0] cap_ip;
  logic [23:0] cap_lat;
  logic        commit;
  logic [13:0] fbytes;

  assign fbytes = {11'(widx - 12'd1), 3'b000} + {11'd0, term_k};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nstate = HDR;
      end
      HDR: begin
        if (start)              nstate = HDR;
        else if (rxc != 8'h00)  nstate = IDLE;
        else if (widx == 12'd7) nstate = BODY;
      end
      BODY: begin
        if (start) begin
          nstate = HDR;
        end else if (rxc != 8'h00) begin
          nstate = IDLE;
          commit = term_ok && match;
        end else if (widx == 12'd2048) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      widx    <= '0;
      match   <= 1'b0;
      cap_ip  <= '0;
      cap_lat <= '0;
    end else if (start) begin
      widx  <= 12'd1;
      match <= 1'b1;
    end else if (state != IDLE && rxc == 8'h00) begin
      widx <= widx + 12'd1;
      if (state == HDR) begin
        unique case (1'b1)
          (widx == 12'd2): begin
            if (lane[4] != 8'h08 || lane[5] != 8'h00 ||
                lane[6] != 8'h45)
              match <= 1'b0;
          end
          (widx == 12'd3): begin
            if (lane[7] != 8'h11) match <= 1'b0;
          end
          (widx == 12'd4): begin
            cap_ip[31:16] <= {lane[6], lane[7]};
          end
          (widx == 12'd5): begin
            cap_ip[15:0] <= {lane[0], lane[1]};
            if ({lane[2], lane[3], lane[4], lane[5]} != 32'h0D5E_0D5E)
              match <= 1'b0;
          end
          (widx == 12'd6): begin
            if ({lane[2], lane[3], lane[4], lane[5], lane[6]} != MAGIC_CODE)
              match <= 1'b0;
          end
          (widx == 12'd7): begin
            cap_lat <= gc - {lane[0], lane[1], lane[2]};
          end
          default: ;
        endcase
      end
    end
  end

  logic [31:0] pps_cnt;
  logic [31:0] byte_cnt;
  logic [31:0] pps_inc;
  logic [32:0] byte_sum;
  logic [31:0] byte_inc;

  assign pps_inc  = (pps_cnt == 32'hFFFF_FFFF) ? pps_cnt : pps_cnt + 32'd1;
  assign byte_sum = {1'b0, byte_cnt} + {19'd0, fbytes};
  assign byte_inc = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pps_cnt       <= '0;
      byte_cnt      <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
      rx_ipv4_ip    <= '0;
    end else begin
      if (tick) begin
        rx_pps        <= pps_cnt;
        rx_throughput <= byte_cnt;
        pps_cnt       <= commit ? 32'd1 : 32'd0;
        byte_cnt      <= commit ? {18'd0, fbytes} : 32'd0;
      end else if (commit) begin
        pps_cnt  <= pps_inc;
        byte_cnt <= byte_inc;
      end
      if (commit) rx_ipv4_ip <= cap_ip;
    end
  end

`ifdef RX_LATENCY_MAX_EN
  logic [23:0] lat_max;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_max    <= '0;
      rx_latency <= '0;
    end else if (tick) begin
      rx_latency <= lat_max;
      lat_max    <= commit ? cap_lat : 24'd0;
    end else if (commit && cap_lat > lat_max) begin
      lat_max <= cap_lat;
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_latency <= '0;
    end else if (commit) begin
      rx_latency <= cap_lat;
    end
  end
`endif

endmodule
